// File: rtl/psum_accumulator.sv
// psum_accumulator: sums groups of signed psum beats into a wide accumulator,
// saturates the group total to OUT_W bits and hands it downstream through a
// one-entry output register with a valid/ready handshake. Backpressure from
// the consumer stalls the incoming psum stream.

module psum_accumulator #(
  parameter int PSUM_W = 32,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [PSUM_W-1:0] psum,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [CNT_W-1:0]  acc_len,
  input  logic              flush,
  output logic [OUT_W-1:0]  acc_out,
  output logic              acc_sat,
  output logic              acc_out_valid,
  input  logic              acc_out_ready,
  output logic              busy
);

  // Clamp limits of the OUT_W signed result, expressed at accumulator width
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // IDLE: no group open; ACCUM: group open (beats taken or flush pending);
  // EMIT: the open group is closed in the current cycle
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  state_t state;
  state_t state_next;
  state_t phase;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             flush_pend;
  logic             ready_en;

  logic             slot_free;
  logic             accept;
  logic             consume;
  logic             flush_req;
  logic [CNT_W-1:0] len_first;
  logic [CNT_W-1:0] len_eff;
  logic             last_beat;
  logic             flush_close;
  logic             close_now;
  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W-1:0] sum_next;

  logic             do_close;
  logic [OUT_W-1:0] sat_val;
  logic             sat_flag;

  // Handshake decode; ready_en keeps psum_ready low while reset is held
  assign slot_free  = !acc_out_valid || acc_out_ready;
  assign psum_ready = ready_en && slot_free;
  assign accept     = psum_valid && psum_ready;
  assign consume    = acc_out_valid && acc_out_ready;
  assign flush_req  = flush || flush_pend;
  assign busy       = (cnt != '0) || flush_pend;

  // A zero group length is treated as a single-beat group
  assign len_first = (acc_len == '0) ? ONE : acc_len;
  assign len_eff   = (state == IDLE) ? len_first : len_q;

  assign last_beat   = accept && (cnt == (len_eff - ONE));
  assign flush_close = flush_req && slot_free && ((state == ACCUM) || accept);
  assign close_now   = last_beat || flush_close;

  assign psum_ext = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
  assign sum_next = acc + (accept ? psum_ext : '0);

  // State register: tracks whether a group is currently open
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a closing cycle is EMIT, after which the group is empty
  always_comb begin
    phase      = state;
    state_next = state;
    if (close_now) begin
      phase = EMIT;
    end
    case (phase)
      IDLE:    state_next = accept ? ACCUM : IDLE;
      ACCUM:   state_next = ACCUM;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: saturate the closing sum into the OUT_W result range
  always_comb begin
    do_close = (phase == EMIT);
    sat_val  = sum_next[OUT_W-1:0];
    sat_flag = 1'b0;
    if ($signed(sum_next) > $signed(SAT_MAX)) begin
      sat_val  = SAT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if ($signed(sum_next) < $signed(SAT_MIN)) begin
      sat_val  = SAT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  // Accumulator, beat counter, latched group length and pending flush
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      acc        <= '0;
      cnt        <= '0;
      len_q      <= ONE;
      flush_pend <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (do_close) begin
        acc        <= '0;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (accept) begin
          acc <= sum_next;
          cnt <= cnt + ONE;
          if (state == IDLE) begin
            len_q <= len_first;
          end
        end
        if (flush && !slot_free && (state == ACCUM)) begin
          flush_pend <= 1'b1;
        end
      end
    end
  end

  // One-entry output register: load on close, clear on consume, else hold
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      acc_out       <= '0;
      acc_sat       <= 1'b0;
      acc_out_valid <= 1'b0;
    end else begin
      if (do_close) begin
        acc_out       <= sat_val;
        acc_sat       <= sat_flag;
        acc_out_valid <= 1'b1;
      end else if (consume) begin
        acc_out_valid <= 1'b0;
      end
    end
  end

endmodule
